// File: rtl/ts_rx_assembler_pkg.sv
// -----------------------------------------------------------------------------
// ts_rx_assembler_pkg
// Shared constants and types for the TS1/TS2 receive assembler.
//   COM_SYM / PAD_SYM : K-code values used for framing and padding
//   TS1_ID / TS2_ID   : ordered-set identifier symbols (symbols 6-15)
//   TS_LEN / TS_W     : ordered-set length in symbols and in bits
//   ts_state_e        : assembler FSM states
// -----------------------------------------------------------------------------
package ts_rx_assembler_pkg;

    localparam logic [7:0] COM_SYM = 8'hBC;  // K28.5
    localparam logic [7:0] PAD_SYM = 8'hF7;  // K23.7
    localparam logic [7:0] TS1_ID  = 8'h4A;  // D10.2
    localparam logic [7:0] TS2_ID  = 8'h45;  // D5.2

    localparam int unsigned TS_LEN = 16;
    localparam int unsigned TS_W   = 8 * TS_LEN;

    // Index of the last symbol in a set; reaching it with a good symbol completes the set.
    localparam logic [3:0] LAST_IDX = 4'(TS_LEN - 1);
    // Index of the identifier symbol that fixes the set type.
    localparam logic [3:0] ID_IDX   = 4'd6;

    typedef enum logic {
        StHunt,
        StCollect
    } ts_state_e;

endpackage

// File: rtl/ts_rx_assembler_sym_check.sv
// -----------------------------------------------------------------------------
// ts_sym_check
// Combinational per-symbol structural check for a TS1/TS2 being collected.
// Ports:
//   i_idx              : position of this symbol within the set (1-15 while collecting)
//   i_sym / i_k        : received symbol and its K flag
//   i_id               : identifier latched from symbol 6 of the current set
//   o_ok               : symbol is legal at this position
//   o_restart_on_com   : symbol is a COM past position 0; the set restarts on it
//   o_id_hit           : symbol 6 is a valid TS1/TS2 identifier
//   o_id_type          : identifier type, 0 = TS1, 1 = TS2
// -----------------------------------------------------------------------------
module ts_sym_check
    import ts_rx_assembler_pkg::*;
#(
    parameter logic [7:0] ComSym = COM_SYM,
    parameter logic [7:0] PadSym = PAD_SYM,
    parameter logic [7:0] Ts1Id  = TS1_ID,
    parameter logic [7:0] Ts2Id  = TS2_ID
) (
    input  logic [3:0] i_idx,
    input  logic [7:0] i_sym,
    input  logic       i_k,
    input  logic [7:0] i_id,
    output logic       o_ok,
    output logic       o_restart_on_com,
    output logic       o_id_hit,
    output logic       o_id_type
);

    logic w_is_com;
    logic w_is_id;
    logic w_pad_slot;

    always_comb begin
        w_is_com   = i_k && (i_sym == ComSym);
        w_is_id    = (i_sym == Ts1Id) || (i_sym == Ts2Id);
        w_pad_slot = (i_idx == 4'd1) || (i_idx == 4'd2);

        o_restart_on_com = w_is_com && (i_idx != 4'd0);
        o_id_hit         = !i_k && (i_idx == ID_IDX) && w_is_id;
        o_id_type        = (i_sym == Ts2Id);

        o_ok = 1'b1;
        if (i_k) begin
            // Only PAD in the link/lane number slots; COM is reported via restart.
            o_ok = w_pad_slot && (i_sym == PadSym);
        end else if (i_idx == ID_IDX) begin
            o_ok = w_is_id;
        end else if (i_idx > ID_IDX) begin
            o_ok = (i_sym == i_id);
        end
    end

endmodule

// File: rtl/ts_rx_assembler.sv
// -----------------------------------------------------------------------------
// ts_rx_assembler
// Hunts for COM in the decoded per-lane symbol stream, collects 16-symbol
// TS1/TS2 ordered sets, checks their structure and presents each good set
// as a 128-bit word with a one-cycle strobe.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_rx_sym, i_rx_k  : received symbol and K flag
//   i_rx_sym_valid    : symbol qualifier; invalid cycles are holes
//   i_rx_elec_idle    : electrical idle, aborts assembly silently
//   o_ts              : last good set, symbol n at [8n+7:8n]
//   o_ts_valid        : one-cycle strobe, o_ts freshly updated
//   o_ts_type         : 0 = TS1, 1 = TS2
//   o_ts_same         : with o_ts_valid, set equals the previous good set
//   o_ts_err          : one-cycle strobe, malformed set discarded
// -----------------------------------------------------------------------------
module ts_rx_assembler
    import ts_rx_assembler_pkg::*;
#(
    parameter logic [7:0] ComSym = COM_SYM,
    parameter logic [7:0] PadSym = PAD_SYM,
    parameter logic [7:0] Ts1Id  = TS1_ID,
    parameter logic [7:0] Ts2Id  = TS2_ID
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [7:0]      i_rx_sym,
    input  logic            i_rx_k,
    input  logic            i_rx_sym_valid,
    input  logic            i_rx_elec_idle,
    output logic [TS_W-1:0] o_ts,
    output logic            o_ts_valid,
    output logic            o_ts_type,
    output logic            o_ts_same,
    output logic            o_ts_err
);

    ts_state_e       r_state;
    logic [3:0]      r_idx;
    logic [TS_W-1:0] r_buf;       // set under construction
    logic [7:0]      r_id;        // identifier latched from symbol 6
    logic            r_id_type;
    logic [TS_W-1:0] r_ts;        // doubles as the previous-good-set register
    logic            r_ts_valid;
    logic            r_ts_type;
    logic            r_ts_same;
    logic            r_ts_err;
    logic            r_prev_ok;

    logic            w_is_com;
    logic            w_ok;
    logic            w_restart;
    logic            w_id_hit;
    logic            w_id_type;
    logic [TS_W-1:0] w_new_ts;

    ts_sym_check #(
        .ComSym (ComSym),
        .PadSym (PadSym),
        .Ts1Id  (Ts1Id),
        .Ts2Id  (Ts2Id)
    ) u_sym_check (
        .i_idx            (r_idx),
        .i_sym            (i_rx_sym),
        .i_k              (i_rx_k),
        .i_id             (r_id),
        .o_ok             (w_ok),
        .o_restart_on_com (w_restart),
        .o_id_hit         (w_id_hit),
        .o_id_type        (w_id_type)
    );

    always_comb begin
        w_is_com = i_rx_k && (i_rx_sym == ComSym);
        // Symbols 0-14 are already in r_buf when the last one arrives.
        w_new_ts = {i_rx_sym, r_buf[TS_W-9:0]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StHunt;
            r_idx      <= 4'd0;
            r_buf      <= '0;
            r_id       <= 8'd0;
            r_id_type  <= 1'b0;
            r_ts       <= '0;
            r_ts_valid <= 1'b0;
            r_ts_type  <= 1'b0;
            r_ts_same  <= 1'b0;
            r_ts_err   <= 1'b0;
            r_prev_ok  <= 1'b0;
        end else begin
            r_ts_valid <= 1'b0;
            r_ts_same  <= 1'b0;
            r_ts_err   <= 1'b0;

            if (i_rx_elec_idle) begin
                // Silent abort; the next good set must not claim to repeat the old one.
                r_state   <= StHunt;
                r_idx     <= 4'd0;
                r_prev_ok <= 1'b0;
            end else if (i_rx_sym_valid) begin
                case (r_state)
                    StHunt: begin
                        if (w_is_com) begin
                            r_buf[7:0] <= i_rx_sym;
                            r_idx      <= 4'd1;
                            r_state    <= StCollect;
                        end
                    end

                    StCollect: begin
                        if (w_restart) begin
                            r_ts_err   <= 1'b1;
                            r_buf[7:0] <= i_rx_sym;
                            r_idx      <= 4'd1;
                        end else if (!w_ok) begin
                            r_ts_err <= 1'b1;
                            r_state  <= StHunt;
                            r_idx    <= 4'd0;
                        end else begin
                            r_buf[{r_idx, 3'b000} +: 8] <= i_rx_sym;
                            if (w_id_hit) begin
                                r_id      <= i_rx_sym;
                                r_id_type <= w_id_type;
                            end
                            if (r_idx == LAST_IDX) begin
                                r_ts       <= w_new_ts;
                                r_ts_valid <= 1'b1;
                                r_ts_type  <= r_id_type;
                                r_ts_same  <= r_prev_ok && (w_new_ts == r_ts);
                                r_prev_ok  <= 1'b1;
                                // Back to HUNT now so a COM next cycle starts a new set.
                                r_state    <= StHunt;
                                r_idx      <= 4'd0;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign o_ts       = r_ts;
    assign o_ts_valid = r_ts_valid;
    assign o_ts_type  = r_ts_type;
    assign o_ts_same  = r_ts_same;
    assign o_ts_err   = r_ts_err;

endmodule

// File: tb/tb_ts_rx_assembler.sv
module tb_ts_rx_assembler;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [7:0]   i_rx_sym = 8'd0;
    logic         i_rx_k = 1'b0;
    logic         i_rx_sym_valid = 1'b0;
    logic         i_rx_elec_idle = 1'b0;
    logic [127:0] o_ts;
    logic         o_ts_valid;
    logic         o_ts_type;
    logic         o_ts_same;
    logic         o_ts_err;

    int n_total = 0;
    int n_bad   = 0;

    // Hand-assembled expected words: BC F7 F7 00 02 00 then ten identifiers.
    localparam logic [127:0] EXP_TS1 =
        {80'h4A4A4A4A4A4A4A4A4A4A, 8'h00, 8'h02, 8'h00, 8'hF7, 8'hF7, 8'hBC};
    localparam logic [127:0] EXP_TS2 =
        {80'h45454545454545454545, 8'h00, 8'h02, 8'h00, 8'hF7, 8'hF7, 8'hBC};

    logic [7:0] v_sym [16];
    logic       v_k   [16];

    always #5 clk = ~clk;

    ts_rx_assembler u_dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_rx_sym       (i_rx_sym),
        .i_rx_k         (i_rx_k),
        .i_rx_sym_valid (i_rx_sym_valid),
        .i_rx_elec_idle (i_rx_elec_idle),
        .o_ts           (o_ts),
        .o_ts_valid     (o_ts_valid),
        .o_ts_type      (o_ts_type),
        .o_ts_same      (o_ts_same),
        .o_ts_err       (o_ts_err)
    );

    // Drive one cycle at the falling edge; on return the outputs reflect the
    // previous rising edge, i.e. the previously driven cycle.
    task automatic drive(input logic v, input logic [7:0] s, input logic k, input logic idle);
        @(negedge clk);
        i_rx_sym_valid = v;
        i_rx_sym       = s;
        i_rx_k         = k;
        i_rx_elec_idle = idle;
    endtask

    task automatic load_ts(input logic [7:0] id);
        v_sym[0] = 8'hBC; v_k[0] = 1'b1;
        v_sym[1] = 8'hF7; v_k[1] = 1'b1;
        v_sym[2] = 8'hF7; v_k[2] = 1'b1;
        v_sym[3] = 8'h00; v_k[3] = 1'b0;
        v_sym[4] = 8'h02; v_k[4] = 1'b0;
        v_sym[5] = 8'h00; v_k[5] = 1'b0;
        for (int i = 6; i < 16; i++) begin
            v_sym[i] = id;
            v_k[i]   = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        n_total++;
        if (o_ts !== 128'd0) begin
            n_bad++; $display("FAIL reset_ts: got %h want 0", o_ts);
        end
        n_total++;
        if ({o_ts_valid, o_ts_type, o_ts_same, o_ts_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {o_ts_valid, o_ts_type, o_ts_same, o_ts_err});
        end
        i_rst = 1'b0;
    endtask

    task automatic test_ts1();
        int early;
        early = 0;
        load_ts(8'h4A);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, v_sym[i], v_k[i], 1'b0);
            if (o_ts_valid || o_ts_err) early++;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++;
        if (early !== 0) begin
            n_bad++; $display("FAIL ts1_early_strobe: got %0d want 0", early);
        end
        n_total++;
        if (o_ts_valid !== 1'b1) begin
            n_bad++; $display("FAIL ts1_valid: got %b want 1", o_ts_valid);
        end
        n_total++;
        if (o_ts !== EXP_TS1) begin
            n_bad++; $display("FAIL ts1_word: got %h want %h", o_ts, EXP_TS1);
        end
        n_total++;
        if (o_ts[7:0] !== 8'hBC || o_ts[127:120] !== 8'h4A) begin
            n_bad++;
            $display("FAIL ts1_ends: got %h/%h want bc/4a", o_ts[7:0], o_ts[127:120]);
        end
        n_total++;
        if ({o_ts_type, o_ts_same, o_ts_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL ts1_flags: got %b want 000", {o_ts_type, o_ts_same, o_ts_err});
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++;
        if (o_ts_valid !== 1'b0 || o_ts !== EXP_TS1) begin
            n_bad++;
            $display("FAIL ts1_one_cycle: got valid=%b ts=%h want 0/%h",
                     o_ts_valid, o_ts, EXP_TS1);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge clk); i_rst = 1'b1;
        @(negedge clk); i_rst = 1'b0;
        load_ts(8'h4A);
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 16; i++) begin
                drive(1'b1, v_sym[i], v_k[i], 1'b0);
                if (o_ts_valid) pulses++;
                if (rep == 1 && i == 0) begin
                    n_total++;
                    if (o_ts_valid !== 1'b1 || o_ts_same !== 1'b0) begin
                        n_bad++;
                        $display("FAIL b2b_first: got valid=%b same=%b want 1/0",
                                 o_ts_valid, o_ts_same);
                    end
                end
                if (rep == 1 && i == 1) begin
                    n_total++;
                    if (o_ts_valid !== 1'b0) begin
                        n_bad++; $display("FAIL b2b_pulse_width: got %b want 0", o_ts_valid);
                    end
                end
            end
        end
        load_ts(8'h45);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, v_sym[i], v_k[i], 1'b0);
            if (o_ts_valid) pulses++;
            if (i == 0) begin
                n_total++;
                if ({o_ts_valid, o_ts_same, o_ts_type} !== 3'b110) begin
                    n_bad++;
                    $display("FAIL b2b_second: got valid/same/type=%b want 110",
                             {o_ts_valid, o_ts_same, o_ts_type});
                end
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (o_ts_valid) pulses++;
        n_total++;
        if ({o_ts_valid, o_ts_type, o_ts_same} !== 3'b110 || o_ts !== EXP_TS2) begin
            n_bad++;
            $display("FAIL b2b_ts2: got valid/type/same=%b ts=%h want 110 %h",
                     {o_ts_valid, o_ts_type, o_ts_same}, o_ts, EXP_TS2);
        end
        n_total++;
        if (pulses !== 3) begin
            n_bad++; $display("FAIL b2b_pulse_count: got %0d want 3", pulses);
        end
    endtask

    task automatic test_bad_id();
        int stray;
        stray = 0;
        load_ts(8'h4A);
        v_sym[11] = 8'h45;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, v_sym[i], v_k[i], 1'b0);
            if (i == 12) begin
                n_total++;
                if (o_ts_err !== 1'b1 || o_ts_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL badid_err: got err=%b valid=%b want 1/0", o_ts_err, o_ts_valid);
                end
            end else if (o_ts_err || o_ts_valid) begin
                stray++;
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (o_ts_err || o_ts_valid) stray++;
        n_total++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL badid_stray: got %0d strobes want 0", stray);
        end
        n_total++;
        if (o_ts !== EXP_TS2 || o_ts_type !== 1'b1) begin
            n_bad++;
            $display("FAIL badid_hold: got %h type=%b want %h type=1", o_ts, o_ts_type, EXP_TS2);
        end
        load_ts(8'h4A);
        for (int i = 0; i < 16; i++) drive(1'b1, v_sym[i], v_k[i], 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++;
        if ({o_ts_valid, o_ts_type, o_ts_same} !== 3'b100 || o_ts !== EXP_TS1) begin
            n_bad++;
            $display("FAIL badid_recover: got valid/type/same=%b ts=%h want 100 %h",
                     {o_ts_valid, o_ts_type, o_ts_same}, o_ts, EXP_TS1);
        end
    endtask

    task automatic test_com_inject();
        int stray;
        stray = 0;
        load_ts(8'h4A);
        for (int i = 0; i < 9; i++) drive(1'b1, v_sym[i], v_k[i], 1'b0);
        drive(1'b1, 8'hBC, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, v_sym[i], v_k[i], 1'b0);
            if (i == 1) begin
                n_total++;
                if (o_ts_err !== 1'b1) begin
                    n_bad++; $display("FAIL com_err: got %b want 1", o_ts_err);
                end
            end else if (o_ts_err || o_ts_valid) begin
                stray++;
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL com_stray: got %0d strobes want 0", stray);
        end
        n_total++;
        if ({o_ts_valid, o_ts_same, o_ts_err} !== 3'b110 || o_ts !== EXP_TS1) begin
            n_bad++;
            $display("FAIL com_restart_set: got valid/same/err=%b ts=%h want 110 %h",
                     {o_ts_valid, o_ts_same, o_ts_err}, o_ts, EXP_TS1);
        end
    endtask

    task automatic test_holes();
        int stray;
        stray = 0;
        load_ts(8'h4A);
        for (int i = 0; i < 5; i++) drive(1'b1, v_sym[i], v_k[i], 1'b0);
        // Hole cycles carry a COM that must be ignored.
        repeat (3) begin
            drive(1'b0, 8'hBC, 1'b1, 1'b0);
            if (o_ts_err || o_ts_valid) stray++;
        end
        for (int i = 5; i < 16; i++) begin
            drive(1'b1, v_sym[i], v_k[i], 1'b0);
            if (o_ts_err || o_ts_valid) stray++;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL holes_stray: got %0d strobes want 0", stray);
        end
        n_total++;
        if ({o_ts_valid, o_ts_same, o_ts_err} !== 3'b110 || o_ts !== EXP_TS1) begin
            n_bad++;
            $display("FAIL holes_set: got valid/same/err=%b ts=%h want 110 %h",
                     {o_ts_valid, o_ts_same, o_ts_err}, o_ts, EXP_TS1);
        end
    endtask

    task automatic test_elec_idle();
        int stray;
        stray = 0;
        load_ts(8'h4A);
        for (int i = 0; i < 8; i++) drive(1'b1, v_sym[i], v_k[i], 1'b0);
        // Idle coincides with a COM; idle must win.
        drive(1'b1, 8'hBC, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++;
        if (o_ts_err !== 1'b0 || o_ts_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_err: got err=%b valid=%b want 0/0", o_ts_err, o_ts_valid);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, v_sym[i], v_k[i], 1'b0);
            if (o_ts_err || o_ts_valid) stray++;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL idle_stray: got %0d strobes want 0", stray);
        end
        n_total++;
        if ({o_ts_valid, o_ts_same} !== 2'b10 || o_ts !== EXP_TS1) begin
            n_bad++;
            $display("FAIL idle_same_cleared: got valid/same=%b ts=%h want 10 %h",
                     {o_ts_valid, o_ts_same}, o_ts, EXP_TS1);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        load_ts(8'h4A);
        for (int i = 0; i < 8; i++) drive(1'b1, v_sym[i], v_k[i], 1'b0);
        drive(1'b1, v_sym[8], v_k[8], 1'b0);
        i_rst = 1'b1;
        drive(1'b1, v_sym[9], v_k[9], 1'b0);
        n_total++;
        if (o_ts !== 128'd0 || {o_ts_valid, o_ts_type, o_ts_same, o_ts_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got ts=%h flags=%b want 0/0000",
                     o_ts, {o_ts_valid, o_ts_type, o_ts_same, o_ts_err});
        end
        i_rst = 1'b0;
        for (int i = 10; i < 16; i++) begin
            drive(1'b1, v_sym[i], v_k[i], 1'b0);
            if (o_ts_err || o_ts_valid) stray++;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (o_ts_err || o_ts_valid) stray++;
        n_total++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL rstmid_partial_dropped: got %0d strobes want 0", stray);
        end
        for (int i = 0; i < 16; i++) drive(1'b1, v_sym[i], v_k[i], 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++;
        if ({o_ts_valid, o_ts_same} !== 2'b10 || o_ts !== EXP_TS1) begin
            n_bad++;
            $display("FAIL rstmid_next_set: got valid/same=%b ts=%h want 10 %h",
                     {o_ts_valid, o_ts_same}, o_ts, EXP_TS1);
        end
    endtask

    initial begin
        test_reset();
        test_ts1();
        test_back_to_back();
        test_bad_id();
        test_com_inject();
        test_holes();
        test_elec_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
